// File: rtl/sam_misc_loader.sv
// sam_misc_loader: buffers the HPS download stream and a hardware fill engine into
// single-byte writes on the SDRAM controller's edge-triggered misc port.
module sam_misc_loader #(
   parameter logic [24:0] BASE     = 25'h0000000,
   parameter logic [24:0] FILL_MAX = 25'h1FFFFFF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ioctl_download,
   input  logic        ioctl_wr,
   input  logic [24:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   output logic        ioctl_wait,
   input  logic        fill_start,
   input  logic [24:0] fill_addr,
   input  logic [24:0] fill_len,
   input  logic [7:0]  fill_val,
   output logic        fill_busy,
   output logic        done,
   output logic        overflow,
   output logic [24:0] misc_addr,
   output logic [7:0]  misc_din,
   output logic        misc_we,
   output logic        misc_rd,
   input  logic        misc_busy
);
   typedef enum logic [2:0] {IDLE, REQ, SETTLE, WAIT, RELEASE} state_t;
   state_t      state;
   logic [24:0] q_addr [4];
   logic [7:0]  q_data [4];
   logic [1:0]  wp, rp;
   logic [2:0]  cnt;
   logic [24:0] fill_ptr, fill_rem;
   logic [7:0]  fill_byte;
   logic        cur_fill, dl_q, fb_q, arm;
   logic        push, take_fill, take_fifo, fill_ok, dl_done;

   assign misc_rd = 1'b0;

   always_comb begin
      push      = ioctl_wr && cnt != 3'd4;
      take_fill = state == IDLE && fill_busy && fill_rem != 25'd0;
      take_fifo = state == IDLE && !fill_busy && cnt != 3'd0;
      fill_ok   = fill_start && fill_len != 25'd0 && !fill_busy && !ioctl_download;
      dl_done   = arm && cnt == 3'd0 && state == IDLE;
   end

   always_ff @(posedge clk) begin
      if (push) begin
         q_addr[wp] <= ioctl_addr + BASE;
         q_data[wp] <= ioctl_dout;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         wp         <= 2'd0;
         rp         <= 2'd0;
         cnt        <= 3'd0;
         fill_ptr   <= 25'd0;
         fill_rem   <= 25'd0;
         fill_byte  <= 8'd0;
         fill_busy  <= 1'b0;
         cur_fill   <= 1'b0;
         dl_q       <= 1'b0;
         fb_q       <= 1'b0;
         arm        <= 1'b0;
         done       <= 1'b0;
         overflow   <= 1'b0;
         ioctl_wait <= 1'b0;
         misc_addr  <= 25'd0;
         misc_din   <= 8'd0;
         misc_we    <= 1'b0;
      end else begin
         dl_q       <= ioctl_download;
         fb_q       <= fill_busy;
         wp         <= push ? wp + 2'd1 : wp;
         rp         <= take_fifo ? rp + 2'd1 : rp;
         cnt        <= cnt + {2'b0, push} - {2'b0, take_fifo};
         overflow   <= overflow | (ioctl_wr && cnt == 3'd4);
         ioctl_wait <= cnt >= 3'd3 || fill_busy;
         arm        <= (arm & ~dl_done) | (dl_q & ~ioctl_download);
         done       <= (fb_q & ~fill_busy) | dl_done;
         if (fill_ok) begin
            fill_ptr  <= fill_addr + BASE;
            fill_rem  <= fill_len > FILL_MAX ? FILL_MAX : fill_len;
            fill_byte <= fill_val;
            fill_busy <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (take_fill) begin
                  misc_addr <= fill_ptr;
                  misc_din  <= fill_byte;
                  fill_ptr  <= fill_ptr + 25'd1;
                  fill_rem  <= fill_rem - 25'd1;
                  cur_fill  <= 1'b1;
                  misc_we   <= 1'b1;
                  state     <= REQ;
               end else if (take_fifo) begin
                  misc_addr <= q_addr[rp];
                  misc_din  <= q_data[rp];
                  cur_fill  <= 1'b0;
                  misc_we   <= 1'b1;
                  state     <= REQ;
               end
            end
            REQ:     state <= SETTLE;
            SETTLE:  state <= WAIT;
            WAIT: begin
               if (!misc_busy) begin
                  misc_we <= 1'b0;
                  state   <= RELEASE;
                  // last fill byte leaves the engine as its write is released
                  if (cur_fill && fill_rem == 25'd0) fill_busy <= 1'b0;
               end
            end
            RELEASE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sam_misc_loader.sv
// tb_sam_misc_loader: directed and random checks of sam_misc_loader against a
// queue-based write scoreboard and a busy-holding controller model.
module tb_sam_misc_loader;
   localparam logic [24:0] BASE = 25'h80000;
   localparam logic [24:0] FMAX = 25'd6;

   logic        clk = 1'b0, reset = 1'b1;
   logic        ioctl_download = 1'b0, ioctl_wr = 1'b0;
   logic [24:0] ioctl_addr = '0;
   logic [7:0]  ioctl_dout = '0;
   logic        fill_start = 1'b0;
   logic [24:0] fill_addr = '0, fill_len = '0;
   logic [7:0]  fill_val = '0;
   logic        ioctl_wait, fill_busy, done, overflow, misc_we, misc_rd;
   logic [24:0] misc_addr;
   logic [7:0]  misc_din;
   logic        misc_busy = 1'b0;

   int errors = 0, checks = 0, hold = 3, done_cnt = 0, bcnt = 0;
   logic we_q = 1'b0;
   logic [24:0] got_a[$], exp_a[$];
   logic [7:0]  got_d[$], exp_d[$];

   sam_misc_loader #(.BASE(BASE), .FILL_MAX(FMAX)) dut (
      .clk(clk), .reset(reset), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
      .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
      .fill_start(fill_start), .fill_addr(fill_addr), .fill_len(fill_len), .fill_val(fill_val),
      .fill_busy(fill_busy), .done(done), .overflow(overflow), .misc_addr(misc_addr),
      .misc_din(misc_din), .misc_we(misc_we), .misc_rd(misc_rd), .misc_busy(misc_busy)
   );

   always #5 clk = ~clk;

   // controller: latches a write on each rising misc_we, then holds busy for hold cycles
   always @(posedge clk) begin
      we_q <= misc_we;
      if (misc_we && !we_q) begin
         got_a.push_back(misc_addr);
         got_d.push_back(misc_din);
         misc_busy <= 1'b1;
         bcnt <= (hold == 0) ? int'($urandom_range(0, 5)) : hold - 1;
      end else if (misc_busy) begin
         if (bcnt == 0) misc_busy <= 1'b0;
         else bcnt <= bcnt - 1;
      end
   end

   always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic exp_write(input logic [24:0] a, input logic [7:0] d);
      logic [24:0] s;
      s = a + BASE;
      exp_a.push_back(s);
      exp_d.push_back(d);
   endtask

   task automatic compare(input string tag);
      check({tag, "_count"}, got_a.size(), exp_a.size());
      for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
         check({tag, "_addr"}, got_a[i], exp_a[i]);
         check({tag, "_data"}, got_d[i], exp_d[i]);
      end
      got_a.delete(); got_d.delete(); exp_a.delete(); exp_d.delete();
   endtask

   task automatic wait_done(input string tag, input int n_exp);
      int k;
      k = 0;
      while (!done && k < 1000) begin step(); k++; end
      check({tag, "_done_seen"}, done, 1);
      check({tag, "_done_after_all"}, got_a.size(), n_exp);
      check({tag, "_we_low"}, misc_we, 0);
   endtask

   task automatic run_fill(input string tag, input logic [24:0] a, input logic [24:0] len, input logic [7:0] v);
      int n, k, bad, d0;
      bit fb_prev;
      n = (len > FMAX) ? int'(FMAX) : int'(len);
      for (int i = 0; i < n; i++) exp_write(a + 25'(i), v);
      d0 = done_cnt;
      fill_addr = a; fill_len = len; fill_val = v; fill_start = 1'b1;
      step();
      fill_start = 1'b0;
      check({tag, "_busy"}, fill_busy, 1);
      fb_prev = 1'b1; k = 0; bad = 0;
      while (fill_busy && k < 400) begin
         fill_start = (k == 3);
         fill_addr = 25'h100; fill_len = 25'd3;
         step();
         if (fill_busy && fb_prev && !ioctl_wait) bad++;
         fb_prev = fill_busy; k++;
      end
      fill_start = 1'b0;
      check({tag, "_busy_falls"}, fill_busy, 0);
      check({tag, "_wait_during"}, bad, 0);
      check({tag, "_wait_lag"}, ioctl_wait, 1);
      check({tag, "_done_early"}, done, 0);
      check({tag, "_writes"}, got_a.size(), n);
      step();
      check({tag, "_done"}, done, 1);
      step();
      check({tag, "_done_once"}, done, 0);
      check({tag, "_done_cnt"}, done_cnt - d0, 1);
      compare(tag);
   endtask

   initial begin
      int d0, k, sent;
      logic [24:0] a;
      logic [7:0] d;
      step(2);
      check("rst_we", misc_we, 0);
      check("rst_rd", misc_rd, 0);
      check("rst_wait", ioctl_wait, 0);
      check("rst_fill_busy", fill_busy, 0);
      check("rst_done", done, 0);
      check("rst_overflow", overflow, 0);
      check("rst_addr", misc_addr, 0);
      check("rst_din", misc_din, 0);
      reset = 1'b0;
      step(2);

      // single byte, cycle exact
      hold = 3;
      ioctl_wr = 1'b1; ioctl_addr = 25'h10; ioctl_dout = 8'hA5;
      exp_write(25'h10, 8'hA5);
      step();
      ioctl_wr = 1'b0;
      check("single_pre_req", misc_we, 0);
      step();
      check("single_req_we", misc_we, 1);
      check("single_req_addr", misc_addr, 25'h80010);
      check("single_req_din", misc_din, 8'hA5);
      check("single_rd", misc_rd, 0);
      step(4);
      check("single_we_held", misc_we, 1);
      step();
      check("single_release_we", misc_we, 0);
      check("single_release_addr", misc_addr, 25'h80010);
      step();
      check("single_idle_we", misc_we, 0);
      check("single_no_done", done, 0);
      compare("single");

      // burst of 6 against a slow controller
      hold = 10;
      ioctl_download = 1'b1;
      step();
      for (int i = 0; i < 6; i++) begin
         d = 8'($urandom);
         ioctl_wr = 1'b1; ioctl_addr = 25'(i * 3); ioctl_dout = d;
         if (i < 5) exp_write(25'(i * 3), d);
         if (i == 4) check("burst_wait_lo", ioctl_wait, 0);
         if (i == 5) begin
            check("burst_wait_hi", ioctl_wait, 1);
            check("burst_ovf_pre", overflow, 0);
         end
         step();
      end
      ioctl_wr = 1'b0;
      check("burst_overflow", overflow, 1);
      d0 = done_cnt;
      ioctl_download = 1'b0;
      wait_done("burst", 5);
      compare("burst");
      step(5);
      check("burst_done_cnt", done_cnt - d0, 1);
      check("burst_ovf_sticky", overflow, 1);

      // fills: plain, clamped, wrapping
      hold = 2;
      run_fill("fill", 25'h0, 25'd5, 8'h00);
      run_fill("fill_clamp", 25'h20, 25'd9, 8'h5A);
      run_fill("fill_wrap", 25'h1F7FFFE, 25'd4, 8'hC3);

      // ignored fills
      d0 = done_cnt;
      fill_len = 25'd0; fill_start = 1'b1;
      step();
      fill_start = 1'b0;
      check("len0_busy", fill_busy, 0);
      step(20);
      check("len0_writes", got_a.size(), 0);
      check("len0_done", done_cnt - d0, 0);
      ioctl_download = 1'b1;
      step();
      fill_len = 25'd3; fill_start = 1'b1;
      step();
      fill_start = 1'b0;
      check("dl_fill_busy", fill_busy, 0);
      step(20);
      check("dl_fill_writes", got_a.size(), 0);
      check("dl_fill_done", done_cnt - d0, 0);
      ioctl_download = 1'b0;
      step(5);

      // reset while a fill write waits on the controller
      hold = 20;
      fill_addr = 25'h40; fill_len = 25'd10; fill_val = 8'h11; fill_start = 1'b1;
      step();
      fill_start = 1'b0;
      step(3);
      check("rst_pre_we", misc_we, 1);
      check("rst_pre_busy", fill_busy, 1);
      #2 reset = 1'b1;
      #1;
      check("rst_async_we", misc_we, 0);
      check("rst_async_fill", fill_busy, 0);
      check("rst_async_wait", ioctl_wait, 0);
      step(2);
      reset = 1'b0;
      got_a.delete(); got_d.delete();
      hold = 2;
      ioctl_wr = 1'b1; ioctl_addr = 25'h33; ioctl_dout = 8'h77;
      exp_write(25'h33, 8'h77);
      step();
      ioctl_wr = 1'b0;
      k = 0;
      while (got_a.size() < 1 && k < 200) begin step(); k++; end
      step(60);
      check("after_rst_ovf", overflow, 0);
      compare("after_rst");

      // random download, host honours ioctl_wait
      hold = 0;
      ioctl_download = 1'b1;
      step();
      sent = 0; k = 0;
      while (sent < 40 && k < 3000) begin
         if (!ioctl_wait && $urandom_range(0, 3) != 0) begin
            a = (sent == 0) ? 25'h1FFFFF0 : 25'($urandom);
            d = 8'($urandom);
            ioctl_wr = 1'b1; ioctl_addr = a; ioctl_dout = d;
            exp_write(a, d);
            sent++;
         end else ioctl_wr = 1'b0;
         step();
         k++;
      end
      ioctl_wr = 1'b0;
      check("rand_sent", sent, 40);
      d0 = done_cnt;
      ioctl_download = 1'b0;
      wait_done("rand", 40);
      compare("rand");
      check("rand_no_overflow", overflow, 0);
      step(5);
      check("rand_done_cnt", done_cnt - d0, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
